// File: rtl/hazard_fwd_unit_pkg.sv
// ============================================================================
// Module  : hazard_fwd_unit_pkg
// Brief   : Shared pipeline constants, shadow-entry type and match helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_fwd_unit_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam logic [3:0] PC_REG  = 4'd15;

    localparam int unsigned STAGES = 3;
    localparam int unsigned STAT_W = 16;

    typedef struct packed {
        logic       valid;
        logic       rf_en;
        logic       load;
        logic [3:0] dest;
    } shadow_entry_t;

    // True when a producing entry supplies the value an operand reads.
    function automatic logic entry_match(input shadow_entry_t e,
                                         input logic          used,
                                         input logic [3:0]    src);
        return used && e.valid && e.rf_en && (e.dest == src) && (src != PC_REG);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_fwd_unit_shadow_stage.sv
// ============================================================================
// Module  : hazard_shadow_stage
// Brief   : One shadow pipeline entry {valid, rf_en, load, dest} with clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_shadow_stage
    import hazard_fwd_unit_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  shadow_entry_t d,
    output shadow_entry_t q
);

    shadow_entry_t r_entry;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_entry <= '0;
        end else if (clear) begin
            r_entry <= '0;
        end else begin
            r_entry <= d;
        end
    end

    assign q = r_entry;

endmodule

`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
// ============================================================================
// Module  : hazard_fwd_unit
// Brief   : Load-use stall, branch flush and operand forwarding control.
//           Optional stall/flush statistics counters under HAZARD_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_fwd_unit
    import hazard_fwd_unit_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] id_ra,
    input  logic [3:0] id_rb,
    input  logic [3:0] id_rd,
    input  logic       id_ra_used,
    input  logic       id_rb_used,
    input  logic       id_rd_used,
    input  logic       id_valid,
    input  logic       id_rf_en,
    input  logic       id_load,
    input  logic [3:0] id_dest,
    input  logic       ex_branch_taken,
    output logic       pc_load_enable,
    output logic       if_id_load_enable,
    output logic       if_id_flush,
    output logic       id_exe_bubble,
    output logic [1:0] fwd_sel_a,
    output logic [1:0] fwd_sel_b,
    output logic [1:0] fwd_sel_d
`ifdef HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_count,
    output logic [STAT_W-1:0] flush_count
`endif
);

    shadow_entry_t w_stage_d [STAGES];
    shadow_entry_t w_stage_q [STAGES];
    logic          w_clear   [STAGES];

    logic w_load_use;
    logic w_stall;
    logic w_flush;

    assign w_stage_d[0] = '{valid: id_valid, rf_en: id_rf_en,
                            load: id_load, dest: id_dest};
    assign w_clear[0]   = id_exe_bubble;

    // Index 0 is EX, 1 is MEM, 2 is WB; the bubble only squashes entry into EX.
    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : g_stage
            if (g > 0) begin : g_chain
                assign w_stage_d[g] = w_stage_q[g-1];
                assign w_clear[g]   = 1'b0;
            end
            hazard_shadow_stage u_stage (
                .clk   (clk),
                .reset (reset),
                .clear (w_clear[g]),
                .d     (w_stage_d[g]),
                .q     (w_stage_q[g])
            );
        end
    endgenerate

    function automatic logic [1:0] fwd_pick(input logic       used,
                                            input logic [3:0] src);
        logic [1:0] sel;
        sel = FWD_RF;
        if (entry_match(w_stage_q[2], used, src)) sel = FWD_WB;
        if (entry_match(w_stage_q[1], used, src)) sel = FWD_MEM;
        if (entry_match(w_stage_q[0], used, src)) sel = FWD_EX;
        return sel;
    endfunction

    always_comb begin
        fwd_sel_a = FWD_RF;
        fwd_sel_b = FWD_RF;
        fwd_sel_d = FWD_RF;
        if (id_valid && !reset) begin
            fwd_sel_a = fwd_pick(id_ra_used, id_ra);
            fwd_sel_b = fwd_pick(id_rb_used, id_rb);
            fwd_sel_d = fwd_pick(id_rd_used, id_rd);
        end
    end

    assign w_load_use = id_valid && w_stage_q[0].valid && w_stage_q[0].load &&
                        (entry_match(w_stage_q[0], id_ra_used, id_ra) ||
                         entry_match(w_stage_q[0], id_rb_used, id_rb) ||
                         entry_match(w_stage_q[0], id_rd_used, id_rd));

    // A taken branch squashes the dependent instruction, so it never stalls.
    assign w_stall = w_load_use && !ex_branch_taken && !reset;
    assign w_flush = ex_branch_taken && !reset;

    assign pc_load_enable    = !w_stall;
    assign if_id_load_enable = !w_stall;
    assign if_id_flush       = w_flush;
    assign id_exe_bubble     = w_stall || w_flush;

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] r_stall_count;
    logic [STAT_W-1:0] r_flush_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_stall && (r_stall_count != {STAT_W{1'b1}})) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
            if (w_flush && (r_flush_count != {STAT_W{1'b1}})) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
        end
    end

    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
// ============================================================================
// Module  : tb_hazard_fwd_unit
// Brief   : Scoreboard bench for hazard_fwd_unit (HAZARD_STATS_EN aware).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_fwd_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] id_ra = '0, id_rb = '0, id_rd = '0, id_dest = '0;
    logic       id_ra_used = 1'b0, id_rb_used = 1'b0, id_rd_used = 1'b0;
    logic       id_valid = 1'b0, id_rf_en = 1'b0, id_load = 1'b0;
    logic       ex_branch_taken = 1'b0;
    logic       pc_load_enable, if_id_load_enable, if_id_flush, id_exe_bubble;
    logic [1:0] fwd_sel_a, fwd_sel_b, fwd_sel_d;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count, flush_count;
`endif

    hazard_fwd_unit dut (
        .clk               (clk),
        .reset             (reset),
        .id_ra             (id_ra),
        .id_rb             (id_rb),
        .id_rd             (id_rd),
        .id_ra_used        (id_ra_used),
        .id_rb_used        (id_rb_used),
        .id_rd_used        (id_rd_used),
        .id_valid          (id_valid),
        .id_rf_en          (id_rf_en),
        .id_load           (id_load),
        .id_dest           (id_dest),
        .ex_branch_taken   (ex_branch_taken),
        .pc_load_enable    (pc_load_enable),
        .if_id_load_enable (if_id_load_enable),
        .if_id_flush       (if_id_flush),
        .id_exe_bubble     (id_exe_bubble),
        .fwd_sel_a         (fwd_sel_a),
        .fwd_sel_b         (fwd_sel_b),
        .fwd_sel_d         (fwd_sel_d)
`ifdef HAZARD_STATS_EN
        ,
        .stall_count       (stall_count),
        .flush_count       (flush_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst, valid, br, rf_en, load;
        bit [3:0] ra, rb, rd, dest;
        bit       ra_u, rb_u, rd_u;
    } stim_t;

    typedef struct { bit v, rf, ld; bit [3:0] d; } ent_t;

    typedef struct { int pc_en, ifid_en, flush, bubble, a, b, d, sc, fc; } exp_t;

    exp_t sbq[$];
    ent_t pipe[3];          // instructions that entered EX, newest first
    int   stall_m = 0, flush_m = 0;
    int   checks = 0, errors = 0;
    event ev_chk;

    function automatic void chk(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endfunction

    // Youngest older instruction writing the register supplies it: 1=EX 2=MEM 3=WB.
    function automatic int ref_sel(bit valid, bit used, bit [3:0] src);
        if (!valid || !used || src == 4'd15) return 0;
        for (int k = 0; k < 3; k++)
            if (pipe[k].v && pipe[k].rf && pipe[k].d == src) return k + 1;
        return 0;
    endfunction

    task automatic issue(input stim_t s);
        exp_t e;
        bit   hz, stall;
        @(negedge clk);
        reset = s.rst;          id_valid = s.valid;   ex_branch_taken = s.br;
        id_ra = s.ra;           id_rb = s.rb;         id_rd = s.rd;
        id_ra_used = s.ra_u;    id_rb_used = s.rb_u;  id_rd_used = s.rd_u;
        id_rf_en = s.rf_en;     id_load = s.load;     id_dest = s.dest;
        #1;
        if (s.rst) begin
            for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 4'd0};
            stall_m = 0;
            flush_m = 0;
        end
        hz = pipe[0].ld && (ref_sel(s.valid, s.ra_u, s.ra) == 1 ||
                            ref_sel(s.valid, s.rb_u, s.rb) == 1 ||
                            ref_sel(s.valid, s.rd_u, s.rd) == 1);
        stall     = !s.rst && hz && !s.br;
        e.pc_en   = !stall;
        e.ifid_en = !stall;
        e.flush   = (!s.rst && s.br) ? 1 : 0;
        e.bubble  = (stall || e.flush != 0) ? 1 : 0;
        e.a  = ref_sel(s.valid, s.ra_u, s.ra);
        e.b  = ref_sel(s.valid, s.rb_u, s.rb);
        e.d  = ref_sel(s.valid, s.rd_u, s.rd);
        e.sc = stall_m;
        e.fc = flush_m;
        sbq.push_back(e);
        ->ev_chk;
        @(posedge clk);
        if (!s.rst) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (e.bubble != 0) ? '{0, 0, 0, 4'd0} : '{s.valid, s.rf_en, s.load, s.dest};
            if (stall && stall_m < 65535) stall_m++;
            if (e.flush != 0 && flush_m < 65535) flush_m++;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(ev_chk);
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("pc_load_enable", int'(pc_load_enable), e.pc_en);
                chk("if_id_load_enable", int'(if_id_load_enable), e.ifid_en);
                chk("if_id_flush", int'(if_id_flush), e.flush);
                chk("id_exe_bubble", int'(id_exe_bubble), e.bubble);
                chk("fwd_sel_a", int'(fwd_sel_a), e.a);
                chk("fwd_sel_b", int'(fwd_sel_b), e.b);
                chk("fwd_sel_d", int'(fwd_sel_d), e.d);
`ifdef HAZARD_STATS_EN
                chk("stall_count", int'(stall_count), e.sc);
                chk("flush_count", int'(flush_count), e.fc);
`endif
            end
        end
    end

    function automatic stim_t nop();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic stim_t wr(bit [3:0] d, bit ld);
        stim_t s = nop();
        s.valid = 1; s.rf_en = 1; s.load = ld; s.dest = d;
        return s;
    endfunction

    function automatic stim_t rd_ops(bit [3:0] a, bit au, bit [3:0] b, bit bu);
        stim_t s = nop();
        s.valid = 1; s.ra = a; s.ra_u = au; s.rb = b; s.rb_u = bu;
        return s;
    endfunction

    function automatic bit [3:0] rnd_reg();
        return ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.rst   = ($urandom_range(0, 59) == 0);
        s.valid = ($urandom_range(0, 7) != 0);
        s.br    = ($urandom_range(0, 7) == 0);
        s.rf_en = ($urandom_range(0, 3) != 0);
        s.load  = ($urandom_range(0, 2) == 0);
        s.ra = rnd_reg(); s.rb = rnd_reg(); s.rd = rnd_reg(); s.dest = rnd_reg();
        s.ra_u = 1'($urandom); s.rb_u = 1'($urandom); s.rd_u = 1'($urandom);
        return s;
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin : stimulus
        stim_t s;
        s = nop(); s.rst = 1;
        issue(s);
        issue(s);
        issue(nop());

        // ALU result in EX forwarded to ra.
        issue(wr(4'd3, 0));
        issue(rd_ops(4'd3, 1, 4'd0, 0));

        // Load then dependent rb: one stall, then MEM forwarding on the held ID.
        issue(wr(4'd4, 1));
        issue(rd_ops(4'd0, 0, 4'd4, 1));
        issue(rd_ops(4'd0, 0, 4'd4, 1));

        // R5 in EX and WB: EX wins.
        issue(wr(4'd5, 0));
        issue(nop());
        issue(wr(4'd5, 0));
        issue(rd_ops(4'd5, 1, 4'd5, 1));

        // Branch coinciding with a load-use hazard.
        issue(wr(4'd6, 1));
        s = rd_ops(4'd6, 1, 4'd0, 0); s.br = 1;
        issue(s);

        // R15 is never forwarded.
        issue(wr(4'd15, 0));
        issue(rd_ops(4'd15, 1, 4'd15, 1));

        // Reset in the middle of a stall, then release: no stall resumes.
        issue(wr(4'd7, 1));
        s = rd_ops(4'd7, 1, 4'd0, 0); s.rst = 1;
        issue(s);
        s.rst = 0;
        issue(s);

        // Three stalls and two flushes from a clean reset.
        s = nop(); s.rst = 1;
        issue(s);
        for (int i = 0; i < 3; i++) begin
            issue(wr(4'd1, 1));
            issue(rd_ops(4'd1, 1, 4'd0, 0));
            issue(rd_ops(4'd1, 1, 4'd0, 0));
        end
        for (int i = 0; i < 2; i++) begin
            s = nop(); s.br = 1;
            issue(s);
        end
        issue(nop());
`ifdef HAZARD_STATS_EN
        chk("stall_count_directed", int'(stall_count), 3);
        chk("flush_count_directed", int'(flush_count), 2);
`endif

        for (int i = 0; i < 400; i++) issue(rnd());
        issue(nop());

        @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
